// File: rtl/ioctl_loader.sv
// ioctl_loader: hps_io download front-end with DIP capture, registered ROM write port and core-reset hold.
// Define IOCTL_CHECKSUM_EN to build the rom_sum byte accumulator; otherwise rom_sum is tied to 0.
module ioctl_loader #(
  parameter int DIP_BYTES = 8,
  parameter int DIP_INDEX = 254,
  parameter int ROM_INDEX = 0,
  parameter int ADDR_W    = 16,
  parameter int RST_HOLD  = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic                   rom_wr,
  output logic [8*DIP_BYTES-1:0] dip_flat,
  output logic                   dip_valid,
  output logic                   rom_loaded,
  output logic                   dl_error,
  output logic                   core_reset,
  output logic [7:0]             rom_sum
);
  typedef enum logic [2:0] {IDLE, LOAD_ROM, LOAD_DIP, LOAD_OTHER, HOLD} state_t;
  state_t state_q, state_d, sel, tgt;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0] rom_data_q, rom_data_d;
  logic rom_wr_q, rom_wr_d;
  logic [8*DIP_BYTES-1:0] dip_q, dip_d;
  logic dip_valid_q, dip_valid_d, loaded_q, loaded_d, err_q, err_d;
  logic waiting, entering_rom, ending, ovf, rom_req, rom_ok, dip_wr;
  // A download seen in IDLE or HOLD is routed by the current index, so its first strobe lands correctly.
  always_comb begin
    sel = (ioctl_index == ROM_INDEX[7:0]) ? LOAD_ROM : (ioctl_index == DIP_INDEX[7:0]) ? LOAD_DIP : LOAD_OTHER;
    waiting = (state_q == IDLE) || (state_q == HOLD);
    tgt = waiting ? sel : state_q;
    entering_rom = waiting && ioctl_download && (sel == LOAD_ROM);
    ending = !waiting && !ioctl_download;
    ovf = |ioctl_addr[24:ADDR_W];
    rom_req = ioctl_download && ioctl_wr && (tgt == LOAD_ROM);
    rom_ok = rom_req && !ovf;
    dip_wr = ioctl_download && ioctl_wr && (tgt == LOAD_DIP);
    state_d = state_q;
    cnt_d = cnt_q;
    if (waiting && ioctl_download) state_d = sel;
    else if (ending) begin
      state_d = HOLD;
      cnt_d = 8'(RST_HOLD);
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q - 8'd1;
      state_d = (cnt_q <= 8'd1) ? IDLE : HOLD;
    end
    rom_wr_d = rom_ok;
    rom_addr_d = rom_ok ? ioctl_addr[ADDR_W-1:0] : rom_addr_q;
    rom_data_d = rom_ok ? ioctl_dout : rom_data_q;
    err_d = (rom_req && ovf) ? 1'b1 : entering_rom ? 1'b0 : err_q;
    loaded_d = entering_rom ? 1'b0 : (ending && state_q == LOAD_ROM) ? !err_q : loaded_q;
    dip_valid_d = dip_valid_q || (dip_wr && ioctl_addr < 25'(DIP_BYTES));
    dip_d = dip_q;
    for (int k = 0; k < DIP_BYTES; k++)
      if (dip_wr && ioctl_addr == 25'(k)) dip_d[8*k +: 8] = ioctl_dout;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q <= 8'(RST_HOLD);
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_wr_q <= 1'b0;
      dip_q <= '0;
      dip_valid_q <= 1'b0;
      loaded_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      rom_wr_q <= rom_wr_d;
      dip_q <= dip_d;
      dip_valid_q <= dip_valid_d;
      loaded_q <= loaded_d;
      err_q <= err_d;
    end
  end
`ifdef IOCTL_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, sum_base;
  always_comb begin
    sum_base = entering_rom ? 8'd0 : sum_q;
    sum_d = rom_ok ? sum_base + ioctl_dout : sum_base;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign rom_sum = sum_q;
`else
  assign rom_sum = '0;
`endif
  assign rom_addr = rom_addr_q;
  assign rom_data = rom_data_q;
  assign rom_wr = rom_wr_q;
  assign dip_flat = dip_q;
  assign dip_valid = dip_valid_q;
  assign rom_loaded = loaded_q;
  assign dl_error = err_q;
  assign core_reset = (state_q != IDLE);
endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed vectors for ioctl_loader with default parameters.
module tb_ioctl_loader;
  logic clk_sys = 1'b0;
  logic reset_n, ioctl_download, ioctl_wr;
  logic [7:0] ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [15:0] rom_addr;
  logic [7:0] rom_data, rom_sum;
  logic rom_wr, dip_valid, rom_loaded, dl_error, core_reset;
  logic [63:0] dip_flat;
  int errs = 0;
  int checks = 0;
  int n;
  typedef struct {
    logic dl; logic [7:0] idx; logic wr; logic [24:0] addr; logic [7:0] dout;
    logic e_wr; logic [15:0] e_addr; logic [7:0] e_data; logic e_rst; logic e_loaded;
  } vec_t;
  vec_t tbl[6];
  ioctl_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_wr(rom_wr), .dip_flat(dip_flat), .dip_valid(dip_valid),
    .rom_loaded(rom_loaded), .dl_error(dl_error), .core_reset(core_reset), .rom_sum(rom_sum)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk_sys);
  endtask
  task automatic drive(input logic dl, input logic [7:0] idx, input logic wr, input logic [24:0] addr, input logic [7:0] d);
    ioctl_download = dl;
    ioctl_index = idx;
    ioctl_wr = wr;
    ioctl_addr = addr;
    ioctl_dout = d;
  endtask
  task automatic hold_count(output int cnt);
    cnt = 0;
    while (core_reset && cnt < 300) begin
      cnt++;
      step();
    end
  endtask
  initial begin
    tbl = '{
      '{1'b1, 8'd0, 1'b1, 25'd0, 8'h11, 1'b1, 16'd0, 8'h11, 1'b1, 1'b0},
      '{1'b1, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 16'd0, 8'h11, 1'b1, 1'b0},
      '{1'b1, 8'd0, 1'b1, 25'd1, 8'h22, 1'b1, 16'd1, 8'h22, 1'b1, 1'b0},
      '{1'b1, 8'd5, 1'b1, 25'd2, 8'h33, 1'b1, 16'd2, 8'h33, 1'b1, 1'b0},
      '{1'b1, 8'd5, 1'b0, 25'd0, 8'h00, 1'b0, 16'd2, 8'h33, 1'b1, 1'b0},
      '{1'b0, 8'd0, 1'b0, 25'd0, 8'h00, 1'b0, 16'd2, 8'h33, 1'b1, 1'b1}
    };
    reset_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    step();
    step();
    chk("rst_rom_wr", rom_wr, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_data", rom_data, 0);
    chk("rst_dip_flat", dip_flat, 0);
    chk("rst_dip_valid", dip_valid, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_dl_error", dl_error, 0);
    chk("rst_rom_sum", rom_sum, 0);
    chk("rst_core_reset", core_reset, 1);
    reset_n = 1'b1;
    hold_count(n);
    chk("rst_hold_len", n, 16);
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].dl, tbl[i].idx, tbl[i].wr, tbl[i].addr, tbl[i].dout);
      step();
      chk($sformatf("rom_v%0d_wr", i), rom_wr, tbl[i].e_wr);
      chk($sformatf("rom_v%0d_addr", i), rom_addr, tbl[i].e_addr);
      chk($sformatf("rom_v%0d_data", i), rom_data, tbl[i].e_data);
      chk($sformatf("rom_v%0d_rst", i), core_reset, tbl[i].e_rst);
      chk($sformatf("rom_v%0d_loaded", i), rom_loaded, tbl[i].e_loaded);
    end
    chk("rom_err", dl_error, 0);
`ifdef IOCTL_CHECKSUM_EN
    chk("rom_sum", rom_sum, 8'h66);
`else
    chk("rom_sum", rom_sum, 8'h00);
`endif
    hold_count(n);
    chk("rom_hold_len", n, 16);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'd254, 1'b1, 25'(i), 8'(8'hA0 + i));
      step();
      chk($sformatf("dip_no_rom_wr_%0d", i), rom_wr, 0);
    end
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    step();
    chk("dip_flat", dip_flat, 64'hA7A6A5A4A3A2A1A0);
    chk("dip_valid", dip_valid, 1);
    chk("dip_keeps_loaded", rom_loaded, 1);
    hold_count(n);
    chk("dip_hold_len", n, 16);
    drive(1'b1, 8'd0, 1'b1, 25'h10000, 8'h55);
    step();
    chk("ovf_no_wr", rom_wr, 0);
    chk("ovf_err", dl_error, 1);
    chk("ovf_loaded_clr", rom_loaded, 0);
    chk("ovf_sum_clr", rom_sum, 0);
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    step();
    chk("ovf_loaded_end", rom_loaded, 0);
    chk("ovf_err_sticky", dl_error, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rehold_rst_%0d", i), core_reset, 1);
    end
    drive(1'b1, 8'd7, 1'b1, 25'd0, 8'h5A);
    step();
    chk("other_rst", core_reset, 1);
    chk("other_no_wr", rom_wr, 0);
    chk("other_dip", dip_flat, 64'hA7A6A5A4A3A2A1A0);
    drive(1'b1, 8'd7, 1'b0, 25'd0, 8'd0);
    step();
    step();
    chk("other_rst_mid", core_reset, 1);
    chk("other_err_kept", dl_error, 1);
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    step();
    hold_count(n);
    chk("rehold_len", n, 16);
    drive(1'b1, 8'd0, 1'b1, 25'd0, 8'h77);
    step();
    chk("mid_wr0", rom_wr, 1);
    chk("mid_err_clr", dl_error, 0);
    drive(1'b1, 8'd0, 1'b1, 25'd1, 8'h88);
    step();
    chk("mid_wr1", rom_wr, 1);
    chk("mid_data1", rom_data, 8'h88);
    reset_n = 1'b0;
    drive(1'b1, 8'd0, 1'b1, 25'd2, 8'h99);
    step();
    chk("mid_rst_wr", rom_wr, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_loaded", rom_loaded, 0);
    chk("mid_rst_dip", dip_flat, 0);
    chk("mid_rst_dip_valid", dip_valid, 0);
    chk("mid_rst_core", core_reset, 1);
    reset_n = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
    hold_count(n);
    chk("mid_hold_len", n, 16);
    chk("mid_end_wr", rom_wr, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
- Parametrised download front-end between hps_io ioctl and an arcade core.
- Successor to the fixed 8-byte DIP capture and plain ROM write gating in the top level. Adds:
  - configurable DIP bank depth and indices
  - a registered ROM write port with overflow detection
  - a download state machine
  - a post-download core-reset hold counter
- Sits in emu, clocked by clk_sys. Outputs drive the core's dn_* ports, DIP inputs and RESET term.

Parameters:
- DIP_BYTES, 8: number of DIP bytes captured (1..32).
- DIP_INDEX, 254: ioctl_index value selecting the DIP bank.
- ROM_INDEX, 0: ioctl_index value selecting ROM data.
- ADDR_W, 16: ROM address width presented to the core.
- RST_HOLD, 16: clk_sys cycles core_reset stays high after a download ends (1..255).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- ioctl_download  in  1  download active (from hps_io).
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  byte write strobe, one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- rom_addr  out  ADDR_W  registered ROM write address.
- rom_data  out  8  registered ROM write data.
- rom_wr  out  1  one-cycle ROM write pulse.
- dip_flat  out  8*DIP_BYTES  DIP bytes; byte k at bits [8k+7:8k].
- dip_valid  out  1  high once a DIP download has delivered at least one byte.
- rom_loaded  out  1  high after a ROM download completes without overflow.
- dl_error  out  1  sticky: ROM address exceeded 2^ADDR_W-1.
- core_reset  out  1  active-high reset request to the core.
- rom_sum  out  8  ROM byte checksum (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at clk edge), all outputs:
  - rom_addr=0, rom_data=0, rom_wr=0, dip_flat=0
  - dip_valid=0, rom_loaded=0, dl_error=0, rom_sum=0
  - core_reset=1; FSM=HOLD with hold counter loaded to RST_HOLD.
  - Reset during a download abandons it. Captured DIP bytes are cleared.
- FSM states:
  - IDLE: core_reset=0.
    - ioctl_download=1 & index==ROM_INDEX -> LOAD_ROM. Clears rom_loaded, dl_error, rom_sum.
    - ioctl_download=1 & index==DIP_INDEX -> LOAD_DIP.
    - ioctl_download=1 with any other index -> LOAD_OTHER.
  - LOAD_ROM / LOAD_DIP / LOAD_OTHER: core_reset=1.
    - On ioctl_download falling -> HOLD; counter=RST_HOLD.
  - HOLD: core_reset=1; counter decrements each cycle.
    - Leaves to IDLE on the cycle counter==1, so core_reset is high for exactly RST_HOLD cycles after the download falls.
    - A new download during HOLD goes directly to the matching LOAD_* state.
- The IDLE->LOAD transition is taken on the same cycle ioctl_download is first seen high. A write strobe on that cycle is processed.
- ROM writes (LOAD_ROM, ioctl_wr=1):
  - Next cycle: rom_wr=1, rom_addr=ioctl_addr[ADDR_W-1:0], rom_data=ioctl_dout. Latency is exactly 1 cycle.
  - If ioctl_addr[24:ADDR_W]!=0: no rom_wr pulse; dl_error set.
- ROM completion: on download end from LOAD_ROM, rom_loaded<=~dl_error.
- DIP writes (LOAD_DIP, ioctl_wr=1):
  - If ioctl_addr < DIP_BYTES: byte ioctl_addr of dip_flat <= ioctl_dout; dip_valid<=1.
  - Addresses >= DIP_BYTES are ignored silently (no error).
- LOAD_OTHER writes are ignored entirely.
- Index compare is sampled each write cycle against the state: index changing mid-download does not retarget writes.
- rom_wr is never asserted outside LOAD_ROM, and never two cycles per strobe.

Optional Feature:
- Macro: IOCTL_CHECKSUM_EN.
- Defined:
  - rom_sum accumulates the 8-bit wrap-around sum of every accepted ROM byte, updated in the same cycle as rom_wr.
  - Cleared on entry to LOAD_ROM.
  - Overflowed bytes are excluded.
- Undefined: rom_sum is tied to 0 and no accumulator is synthesised.

Test Plan:
- Reset with reset_n=0 for 2 cycles, then 1:
  - all outputs at reset values; core_reset=1 for 16 cycles, then 0.
- ROM download, index 0, bytes 0x11,0x22,0x33 at addr 0..2:
  - three single-cycle rom_wr pulses, each 1 cycle after its ioctl_wr, with matching addr/data;
  - rom_loaded=1 after end; rom_sum=0x66 with IOCTL_CHECKSUM_EN, 0 without.
- DIP download, index 254, addr 0..9 data 0xA0..0xA9, DIP_BYTES=8:
  - dip_flat=0xA7A6A5A4A3A2A1A0; dip_valid=1; no rom_wr.
- ROM write at ioctl_addr=0x10000 (ADDR_W=16):
  - no rom_wr; dl_error=1; rom_loaded=0 after end.
- Download end, then new download 5 cycles into HOLD:
  - core_reset stays high continuously; FSM enters LOAD_*; full 16-cycle hold restarts after second end.
- reset_n=0 mid-ROM download after 2 bytes:
  - rom_wr stops; rom_loaded=0; dip_flat=0; core_reset=1 until hold expires.
